// File: rtl/ti_share_encoder.sv
// rtl/ti_share_encoder.sv - splits nibbles into NSHARES Boolean shares using fresh LFSR randomness
module ti_share_encoder #(
  parameter int                NSHARES = 3,
  parameter int                LFSR_W  = 32,
  parameter logic [LFSR_W-1:0] POLY    = LFSR_W'(32'h80200003),
  parameter int                WARMUP  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_load,
  input  logic [LFSR_W-1:0]      seed_value,
  input  logic [3:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*NSHARES-1:0]   out_shares,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {ST_SEED_WAIT, ST_WARMUP, ST_RUN} state_t;

  localparam int          WL    = (WARMUP > 0) ? WARMUP - 1 : 0;
  localparam logic [7:0]  WLAST = WL[7:0];

  state_t              state, state_nxt;
  logic [LFSR_W-1:0]   lfsr, lfsr_nxt, lfsr_step;
  logic [7:0]          wcnt, wcnt_nxt;
  logic [4*NSHARES-1:0] enc;
  logic [3:0]          share0;
  logic                accept;

  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
  assign in_ready  = (state == ST_RUN) && !seed_load && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != ST_RUN);

  // Random shares come from the current LFSR state; share0 absorbs the data.
  always_comb begin
    enc    = '0;
    share0 = in_data;
    for (int j = 1; j < NSHARES; j++) begin
      enc[4*j +: 4] = lfsr[4*(j-1) +: 4];
      share0        = share0 ^ lfsr[4*(j-1) +: 4];
    end
    enc[3:0] = share0;
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    wcnt_nxt  = wcnt;
    if (seed_load) begin
      lfsr_nxt  = (seed_value == '0) ? LFSR_W'(1) : seed_value;
      wcnt_nxt  = '0;
      state_nxt = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
    end else begin
      case (state)
        ST_WARMUP: begin
          lfsr_nxt = lfsr_step;
          wcnt_nxt = wcnt + 8'd1;
          if (wcnt == WLAST) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (accept) lfsr_nxt = lfsr_step;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SEED_WAIT;
      lfsr       <= LFSR_W'(1);
      wcnt       <= '0;
      out_valid  <= 1'b0;
      out_shares <= '0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      wcnt  <= wcnt_nxt;
      // A reseed discards any pending word so no share reuses stale randomness.
      if (seed_load) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_shares <= enc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
